// File: rtl/char_scroll_feeder_if.sv
// Bus between the scroll feeder, its switch-driven input path and the
// display multiplexer. The feeder sits on the master side.
//
// Handshake: load is a one-way strobe with no ready; the display latches
// data into char_position on every cycle load=1. wr_en, clear and
// scroll_en are level inputs sampled on each rising edge; there is no
// back-pressure, so a write while full is silently dropped.
interface char_scroll_feeder_if #(
   parameter int MSG_DEPTH = 16
);
   localparam int LEN_W = $clog2(MSG_DEPTH) + 1;

   logic [3:0]       wr_data;
   logic             wr_en;
   logic             clear;
   logic             scroll_en;
   logic [3:0]       data;
   logic [1:0]       char_position;
   logic             load;
   logic             busy;
   logic [LEN_W-1:0] msg_len;
   logic             full;
   logic             state_dbg;   // 1 while the refresh walk is running

   modport master (
      input  wr_data, wr_en, clear, scroll_en,
      output data, char_position, load, busy, msg_len, full, state_dbg
   );

   modport slave (
      output wr_data, wr_en, clear, scroll_en,
      input  data, char_position, load, busy, msg_len, full, state_dbg
   );
endinterface

// File: rtl/char_scroll_feeder.sv
// Message buffer plus scroll engine feeding a 4-position character display.
// Any change to the visible window (write, clear, scroll step) raises a
// pending flag; the refresh FSM then rewrites all four positions in order.
module char_scroll_feeder #(
   parameter int unsigned TICK_COUNT = 10_000_000,
   parameter int          MSG_DEPTH  = 16,
   parameter logic [3:0]  BLANK_CODE = 4'hF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   char_scroll_feeder_if.master  bus
);
   localparam int IDX_W = $clog2(MSG_DEPTH);
   localparam int LEN_W = IDX_W + 1;
   localparam int CNT_W = $clog2(TICK_COUNT);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_REFRESH = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [3:0]       msg_buf [MSG_DEPTH];
   logic [LEN_W-1:0] msg_len;
   logic [IDX_W-1:0] head;
   logic [CNT_W-1:0] tick_cnt;
   logic             pending;
   logic [IDX_W-1:0] idx, idx_next;
   logic [1:0]       pos, pos_next;
   logic             load_q, load_next;
   logic [3:0]       data_q, data_next;
   logic [1:0]       cpos_q, cpos_next;
   logic             start;
   logic             full;
   logic             wr_ok;
   logic             tick;
   logic             event_hit;
   logic [LEN_W-1:0] idx_inc;
   logic [LEN_W-1:0] head_inc;

   assign full      = (msg_len == LEN_W'(MSG_DEPTH));
   // clear wins over a simultaneous write
   assign wr_ok     = bus.wr_en && !full && !bus.clear;
   assign tick      = !bus.clear && bus.scroll_en && (msg_len != '0) &&
                      (tick_cnt == CNT_W'(TICK_COUNT - 1));
   assign event_hit = bus.clear | wr_ok | tick;
   assign idx_inc   = {1'b0, idx} + LEN_W'(1);
   assign head_inc  = {1'b0, head} + LEN_W'(1);

   // Message length, window start and scroll tick counter
   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear) begin
         msg_len  <= '0;
         head     <= '0;
         tick_cnt <= '0;
      end else begin
         if (wr_ok) msg_len <= msg_len + LEN_W'(1);
         if (bus.scroll_en && msg_len != '0) begin
            if (tick) begin
               tick_cnt <= '0;
               head     <= (head_inc == msg_len) ? '0 : head_inc[IDX_W-1:0];
            end else begin
               tick_cnt <= tick_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Character storage; contents need no reset since msg_len bounds reads
   always_ff @(posedge clk) begin
      if (rst_n && wr_ok) msg_buf[msg_len[IDX_W-1:0]] <= bus.wr_data;
   end

   // Pending refresh flag: a new event outranks the FSM consuming it
   always_ff @(posedge clk) begin
      if (!rst_n)         pending <= 1'b1;
      else if (event_hit) pending <= 1'b1;
      else if (start)     pending <= 1'b0;
   end

   // FSM state and registered display outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         idx    <= '0;
         pos    <= '0;
         load_q <= 1'b0;
         data_q <= BLANK_CODE;
         cpos_q <= '0;
      end else begin
         state  <= state_next;
         idx    <= idx_next;
         pos    <= pos_next;
         load_q <= load_next;
         data_q <= data_next;
         cpos_q <= cpos_next;
      end
   end

   // Next state: walk four positions, chaining straight into another walk
   // when something changed meanwhile
   always_comb begin
      state_next = state;
      idx_next   = idx;
      pos_next   = pos;
      load_next  = 1'b0;
      data_next  = data_q;
      cpos_next  = cpos_q;
      start      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pending) begin
               state_next = ST_REFRESH;
               start      = 1'b1;
            end
         end
         ST_REFRESH: begin
            load_next = 1'b1;
            cpos_next = pos;
            // msg_len checked every cycle so a clear blanks the rest at once
            data_next = (msg_len == '0) ? BLANK_CODE : msg_buf[idx];
            idx_next  = (idx_inc >= msg_len) ? '0 : idx_inc[IDX_W-1:0];
            pos_next  = pos + 2'd1;
            if (pos == 2'd3) begin
               if (pending) start      = 1'b1;
               else         state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (start) begin
         idx_next = head;
         pos_next = '0;
      end
   end

   assign bus.load          = load_q;
   assign bus.busy          = load_q;
   assign bus.data          = data_q;
   assign bus.char_position = cpos_q;
   assign bus.msg_len       = msg_len;
   assign bus.full          = full;
   assign bus.state_dbg     = (state == ST_REFRESH);
endmodule

// File: tb/tb_char_scroll_feeder.sv
// Bench for char_scroll_feeder: directed scenarios with hand-computed
// literal expectations, then a randomized run, all compared every cycle
// against a message-level reference model.
module tb_char_scroll_feeder;
   localparam int         TC    = 8;
   localparam int         DEPTH = 16;
   localparam logic [3:0] BLANK = 4'hF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   char_scroll_feeder_if #(.MSG_DEPTH(DEPTH)) bus ();

   char_scroll_feeder #(
      .TICK_COUNT(TC),
      .MSG_DEPTH (DEPTH),
      .BLANK_CODE(BLANK)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard counters ----------------
   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Message kept as a plain array plus length; a refresh is "4 loads still
   // owed" starting from the window head captured when it begins.
   logic [3:0] m_buf [DEPTH];
   int         m_len = 0, m_head = 0, m_cnt = 0;
   int         m_seq_left = 0, m_walk = 0;
   bit         m_pending = 1'b1;
   bit         model_valid = 1'b0;
   logic       exp_load = 1'b0;
   logic [3:0] exp_data = BLANK;
   int         exp_pos = 0;

   always @(posedge clk) begin : model
      bit start, ev, do_tick, do_wr;
      model_valid <= 1'b1;
      if (!rst_n) begin
         m_len = 0; m_head = 0; m_cnt = 0; m_pending = 1'b1;
         m_seq_left = 0; m_walk = 0;
         exp_load = 1'b0; exp_data = BLANK; exp_pos = 0;
      end else begin
         start = 1'b0;
         if (m_seq_left == 0) begin
            exp_load = 1'b0;
            if (m_pending) start = 1'b1;
         end else begin
            exp_load = 1'b1;
            exp_pos  = 4 - m_seq_left;
            exp_data = (m_len == 0) ? BLANK : m_buf[m_walk];
            m_walk   = (m_walk + 1 >= m_len) ? 0 : m_walk + 1;
            m_seq_left--;
            if (m_seq_left == 0 && m_pending) start = 1'b1;
         end
         if (start) begin
            m_seq_left = 4; m_walk = m_head; m_pending = 1'b0;
         end
         ev = 1'b0;
         if (bus.clear) begin
            m_len = 0; m_head = 0; m_cnt = 0; ev = 1'b1;
         end else begin
            do_wr   = bus.wr_en && (m_len < DEPTH);
            do_tick = bus.scroll_en && (m_len > 0) && (m_cnt == TC - 1);
            if (bus.scroll_en && m_len > 0) begin
               if (do_tick) begin
                  m_cnt  = 0;
                  m_head = (m_head + 1 == m_len) ? 0 : m_head + 1;
               end else begin
                  m_cnt++;
               end
            end
            if (do_wr) begin
               m_buf[m_len] = bus.wr_data;
               m_len++;
            end
            ev = do_wr || do_tick;
         end
         if (ev) m_pending = 1'b1;
      end
   end

   // ---------------- compare process ----------------
   logic [3:0] load_log [$];
   int         busy_run = 0, last_run = 0;

   always @(negedge clk) begin
      if (model_valid) begin
         check("load", bus.load, exp_load);
         check("busy", bus.busy, exp_load);
         check("data", bus.data, exp_data);
         check("char_position", bus.char_position, exp_pos);
         check("msg_len", bus.msg_len, m_len);
         check("full", bus.full, m_len == DEPTH);
         if (bus.load) load_log.push_back(bus.data);
         if (bus.busy) busy_run++;
         else begin
            if (busy_run != 0) last_run = busy_run;
            busy_run = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_char(input logic [3:0] c);
      bus.wr_data = c;
      bus.wr_en   = 1'b1;
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
   endtask

   task automatic wait_load_pos(input int p);
      int n = 0;
      while (!(bus.load && bus.char_position == p) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_load_timeout", n < 50, 1'b1);
   endtask

   // exp4 holds the four expected codes, position 0 in the top nibble
   task automatic check_tail(input string name, input logic [15:0] exp4);
      int sz = load_log.size();
      if (sz < 4) check(name, sz, 4);
      else for (int i = 0; i < 4; i++)
         check(name, load_log[sz - 4 + i], exp4[15 - 4*i -: 4]);
   endtask

   // ---------------- stimulus ----------------
   logic [3:0] scroll_exp [24] = '{4'd2, 4'd3, 4'd4, 4'd5,  4'd3, 4'd4, 4'd5, 4'd1,
                                   4'd4, 4'd5, 4'd1, 4'd2,  4'd5, 4'd1, 4'd2, 4'd3,
                                   4'd1, 4'd2, 4'd3, 4'd4,  4'd2, 4'd3, 4'd4, 4'd5};

   initial begin
      bus.wr_data = '0; bus.wr_en = 1'b0; bus.clear = 1'b0; bus.scroll_en = 1'b0;

      // reset values
      idle(3);
      check("rst_load", bus.load, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_data", bus.data, BLANK);
      check("rst_pos", bus.char_position, 2'd0);
      check("rst_msg_len", bus.msg_len, 0);
      check("rst_full", bus.full, 1'b0);
      rst_n = 1'b1;

      // blank refresh right after reset
      idle(8);
      check("reset_load_count", load_log.size(), 4);
      check_tail("reset_blank", 16'hFFFF);
      check("reset_busy_run", last_run, 4);

      // write and wrap on a short message
      write_char(4'd1); write_char(4'd2); write_char(4'd3);
      idle(14);
      check_tail("wrap_123", 16'h1231);
      check("wrap_msg_len", bus.msg_len, 3);
      check("wrap_full", bus.full, 1'b0);

      // scrolling windows over "12345"
      do_clear();
      for (int i = 1; i <= 5; i++) write_char(4'(i));
      idle(10);
      load_log.delete();
      bus.scroll_en = 1'b1;
      idle(52);
      bus.scroll_en = 1'b0;
      idle(8);
      check("scroll_load_count", load_log.size(), 24);
      for (int i = 0; i < 24 && i < load_log.size(); i++)
         check("scroll_window", load_log[i], scroll_exp[i]);

      // fill to full, overflow write dropped
      do_clear();
      for (int i = 0; i < 16; i++) write_char(4'($urandom_range(0, 14)));
      check("full_after_16", bus.full, 1'b1);
      check("len_after_16", bus.msg_len, 16);
      write_char(4'h7);
      check("len_after_17", bus.msg_len, 16);
      idle(10);

      // clear beats a simultaneous write
      do_clear();
      for (int i = 0; i < 5; i++) write_char(4'($urandom_range(0, 14)));
      idle(3);
      bus.clear = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 4'h6;
      @(negedge clk);
      bus.clear = 1'b0; bus.wr_en = 1'b0;
      check("clr_wr_len", bus.msg_len, 0);
      idle(12);
      check_tail("clr_wr_blank", 16'hFFFF);

      // write during position-1 load: back-to-back sequences
      write_char(4'd4); write_char(4'd5); write_char(4'd6);
      idle(12);
      write_char(4'd9);
      wait_load_pos(1);
      bus.wr_data = 4'hA; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
      idle(14);
      check("busy_run_8", last_run, 8);
      check_tail("chain_tail", 16'h4569);

      // reset in the middle of a refresh
      write_char(4'd2);
      wait_load_pos(0);
      rst_n = 1'b0;
      @(negedge clk);
      check("reset_abort_load", bus.load, 1'b0);
      rst_n = 1'b1;
      idle(8);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bus.wr_en   = ($urandom_range(0, 1) == 0);
         bus.wr_data = 4'($urandom_range(0, 15));
         bus.clear   = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 15) == 0) bus.scroll_en = ~bus.scroll_en;
         rst_n       = ($urandom_range(0, 499) != 0);
         @(negedge clk);
      end
      bus.wr_en = 1'b0; bus.clear = 1'b0; bus.scroll_en = 1'b0; rst_n = 1'b1;
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
